// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and data ports onto a byte-wide RAM,
// serialising 1/2/4-byte accesses and assembling little-endian read data.
module mem_ctrl #(
   parameter int unsigned ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic              if_done_o,
   output logic [31:0]       if_data_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_len_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic              mem_done_o,
   output logic [31:0]       mem_rdata_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i,
   output logic              busy_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD      = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR      = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         buf_q, buf_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [1:0]          last_q, last_d;      // index of final byte (N-1)
   logic                sel_mem_q, sel_mem_d;
   logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
   logic                ram_wr_q, ram_wr_d;
   logic [7:0]          ram_dout_q, ram_dout_d;
   logic                if_done_q, if_done_d;
   logic                mem_done_q, mem_done_d;
   logic [31:0]         if_data_q, if_data_d;
   logic [31:0]         mem_rdata_q, mem_rdata_d;
   logic                busy_q, busy_d;

   logic [1:0]          prev_idx;
   logic [1:0]          next_idx;
   logic [31:0]         byte_mask;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      sel_mem_d   = sel_mem_q;
      ram_a_d     = ram_a_q;
      ram_wr_d    = 1'b0;
      ram_dout_d  = ram_dout_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      prev_idx    = cnt_q - 2'd1;
      next_idx    = cnt_q + 2'd1;
      byte_mask   = 32'd0;

      for (int b = 0; b < 4; b++) begin
         if (2'(b) <= last_q) byte_mask[8*b +: 8] = 8'hFF;
      end

      case (state_q)
         S_IDLE: begin
            if (mem_req_i) begin
               sel_mem_d = 1'b1;
               addr_d    = mem_addr_i;
               wdata_d   = mem_wdata_i;
               cnt_d     = 2'd0;
               buf_d     = 32'd0;
               ram_a_d   = ADDR_W'(mem_addr_i);
               case (mem_len_i)
                  2'b00:   last_d = 2'd0;
                  2'b01:   last_d = 2'd1;
                  default: last_d = 2'd3;
               endcase
               if (mem_we_i) begin
                  state_d    = S_WR;
                  ram_wr_d   = 1'b1;
                  ram_dout_d = mem_wdata_i[7:0];
               end else begin
                  state_d    = S_RD;
               end
            end else if (if_req_i) begin
               sel_mem_d = 1'b0;
               addr_d    = if_addr_i;
               cnt_d     = 2'd0;
               buf_d     = 32'd0;
               last_d    = 2'd3;
               ram_a_d   = ADDR_W'(if_addr_i);
               state_d   = S_RD;
            end
         end

         S_RD: begin
            if (cnt_q != 2'd0) buf_d[{prev_idx, 3'b000} +: 8] = ram_din_i;
            if (cnt_q == last_q) begin
               state_d = S_RD_WAIT;
            end else begin
               cnt_d   = next_idx;
               ram_a_d = ADDR_W'(addr_q + 32'(next_idx));
            end
         end

         S_RD_WAIT: begin
            buf_d[{last_q, 3'b000} +: 8] = ram_din_i;
            state_d = S_DONE;
            if (sel_mem_q) begin
               mem_done_d  = 1'b1;
               mem_rdata_d = buf_d & byte_mask;
            end else begin
               if_done_d   = 1'b1;
               if_data_d   = buf_d & byte_mask;
            end
         end

         S_WR: begin
            if (cnt_q == last_q) begin
               state_d     = S_DONE;
               mem_done_d  = 1'b1;
               mem_rdata_d = 32'd0;
            end else begin
               cnt_d      = next_idx;
               ram_wr_d   = 1'b1;
               ram_a_d    = ADDR_W'(addr_q + 32'(next_idx));
               ram_dout_d = wdata_q[{next_idx, 3'b000} +: 8];
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         buf_q       <= 32'd0;
         cnt_q       <= 2'd0;
         last_q      <= 2'd0;
         sel_mem_q   <= 1'b0;
         ram_a_q     <= '0;
         ram_wr_q    <= 1'b0;
         ram_dout_q  <= 8'd0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_data_q   <= 32'd0;
         mem_rdata_q <= 32'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         sel_mem_q   <= sel_mem_d;
         ram_a_q     <= ram_a_d;
         ram_wr_q    <= ram_wr_d;
         ram_dout_q  <= ram_dout_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_done_o   = if_done_q;
   assign if_data_o   = if_data_q;
   assign mem_done_o  = mem_done_q;
   assign mem_rdata_o = mem_rdata_q;
   assign ram_a_o     = ram_a_q;
   assign ram_wr_o    = ram_wr_q;
   assign ram_dout_o  = ram_dout_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector bench for mem_ctrl with a behavioural byte RAM.
module tb_mem_ctrl;

   localparam int unsigned ADDR_W = 17;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req_i;
   logic [31:0]       if_addr_i;
   logic              if_done_o;
   logic [31:0]       if_data_o;
   logic              mem_req_i;
   logic              mem_we_i;
   logic [1:0]        mem_len_i;
   logic [31:0]       mem_addr_i;
   logic [31:0]       mem_wdata_i;
   logic              mem_done_o;
   logic [31:0]       mem_rdata_o;
   logic [ADDR_W-1:0] ram_a_o;
   logic              ram_wr_o;
   logic [7:0]        ram_dout_o;
   logic [7:0]        ram_din_i;
   logic              busy_o;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram [DEPTH];

   mem_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_done_o   (if_done_o),
      .if_data_o   (if_data_o),
      .mem_req_i   (mem_req_i),
      .mem_we_i    (mem_we_i),
      .mem_len_i   (mem_len_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_done_o  (mem_done_o),
      .mem_rdata_o (mem_rdata_o),
      .ram_a_o     (ram_a_o),
      .ram_wr_o    (ram_wr_o),
      .ram_dout_o  (ram_dout_o),
      .ram_din_i   (ram_din_i),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   // Byte RAM: synchronous write, read data valid one cycle after address
   always @(posedge clk) begin
      if (ram_wr_o) ram[ram_a_o] <= ram_dout_o;
      ram_din_i <= ram[ram_a_o];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_nwr;
      logic [16:0] exp_wa0;
   } vec_t;

   // Data-port transaction; returns data, latency (cycles from accept), write count
   task automatic mem_txn(input logic we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int lat, output int nwr, output logic [16:0] wa0);
      @(negedge clk);
      mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len;
      mem_addr_i = addr; mem_wdata_i = wdata;
      lat = -1; nwr = 0; rdata = 32'hX; wa0 = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (ram_wr_o) begin
            if (nwr == 0) wa0 = ram_a_o;
            nwr++;
         end
         if (mem_done_o) begin
            lat = c; rdata = mem_rdata_o;
            break;
         end
      end
      mem_req_i = 1'b0;
   endtask

   // Fetch transaction; also records ram_a_o for the first four cycles
   task automatic if_txn(input logic [31:0] addr, output logic [31:0] data, output int lat,
                         output logic [16:0] a0, output logic [16:0] a3);
      @(negedge clk);
      if_req_i = 1'b1; if_addr_i = addr;
      lat = -1; data = 32'hX; a0 = '0; a3 = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) a0 = ram_a_o;
         if (c == 4) a3 = ram_a_o;
         if (if_done_o) begin
            lat = c; data = if_data_o;
            break;
         end
      end
      if_req_i = 1'b0;
   endtask

   vec_t vecs [11];

   initial begin
      logic [31:0] rd;
      logic [16:0] a0, a3, wa0;
      int lat, nwr, md_cyc, id_cyc, md_cnt, id_cnt, stray;
      logic [31:0] md_data, id_data;

      for (int a = 0; a < int'(DEPTH); a++) ram[a] = 8'h00;
      ram[17'h100] = 8'h13;
      ram[17'h300] = 8'h11; ram[17'h301] = 8'h22;
      ram[17'h302] = 8'h33; ram[17'h303] = 8'h44;

      vecs[0]  = '{1'b1, 2'b00, 32'h0000_0205, 32'hDEAD_BEEF, 32'h0,          2, 1, 17'h00205};
      vecs[1]  = '{1'b0, 2'b00, 32'h0000_0205, 32'h0,         32'h0000_00EF, 3, 0, 17'h0};
      vecs[2]  = '{1'b0, 2'b10, 32'h0000_0300, 32'h0,         32'h4433_2211, 6, 0, 17'h0};
      vecs[3]  = '{1'b0, 2'b01, 32'h0000_0301, 32'h0,         32'h0000_3322, 4, 0, 17'h0};
      vecs[4]  = '{1'b1, 2'b10, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,          5, 4, 17'h00400};
      vecs[5]  = '{1'b0, 2'b10, 32'h0000_0400, 32'h0,         32'hCAFE_F00D, 6, 0, 17'h0};
      vecs[6]  = '{1'b0, 2'b11, 32'h0000_0400, 32'h0,         32'hCAFE_F00D, 6, 0, 17'h0};
      vecs[7]  = '{1'b1, 2'b01, 32'h0001_FFFF, 32'h0000_ABCD, 32'h0,          3, 2, 17'h1FFFF};
      vecs[8]  = '{1'b0, 2'b01, 32'h0001_FFFF, 32'h0,         32'h0000_ABCD, 4, 0, 17'h0};
      vecs[9]  = '{1'b0, 2'b10, 32'h0002_0300, 32'h0,         32'h4433_2211, 6, 0, 17'h0};
      vecs[10] = '{1'b0, 2'b00, 32'h0000_0302, 32'h0,         32'h0000_0033, 3, 0, 17'h0};

      rst = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
      mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy",   32'(busy_o),     32'h0);
      chk("reset ram_wr", 32'(ram_wr_o),   32'h0);
      chk("reset ifdone", 32'(if_done_o),  32'h0);
      chk("reset mdone",  32'(mem_done_o), 32'h0);
      chk("reset rdata",  mem_rdata_o,     32'h0);
      chk("reset ram_a",  32'(ram_a_o),    32'h0);
      rst = 1'b1;

      // Word fetch
      if_txn(32'h100, rd, lat, a0, a3);
      chk("fetch data", rd, 32'h0000_0013);
      chk("fetch lat",  32'(lat), 32'd6);
      chk("fetch a0",   32'(a0),  32'h100);
      chk("fetch a3",   32'(a3),  32'h103);

      // Vector table; consecutive entries are back-to-back with no idle gap
      for (int v = 0; v < 11; v++) begin
         mem_txn(vecs[v].we, vecs[v].len, vecs[v].addr, vecs[v].wdata, rd, lat, nwr, wa0);
         chk($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rdata);
         chk($sformatf("vec%0d lat", v),   32'(lat), 32'(vecs[v].exp_lat));
         chk($sformatf("vec%0d nwr", v),   32'(nwr), 32'(vecs[v].exp_nwr));
         if (vecs[v].we) chk($sformatf("vec%0d wa0", v), 32'(wa0), 32'(vecs[v].exp_wa0));
      end
      chk("wrap lo byte", 32'(ram[17'h1FFFF]), 32'hCD);
      chk("wrap hi byte", 32'(ram[17'h00000]), 32'hAB);
      chk("byte st nbr",  32'(ram[17'h00206]), 32'h00);

      // Reset in the middle of a word fetch
      @(negedge clk);
      if_req_i = 1'b1; if_addr_i = 32'h300;
      repeat (2) @(negedge clk);
      chk("midrd busy pre", 32'(busy_o), 32'h1);
      rst = 1'b0; if_req_i = 1'b0;
      @(negedge clk);
      chk("midrd busy",   32'(busy_o),    32'h0);
      chk("midrd ram_wr", 32'(ram_wr_o),  32'h0);
      rst = 1'b1;
      stray = 0;
      for (int c = 0; c < 8; c++) begin
         if (if_done_o) stray++;
         @(negedge clk);
      end
      chk("midrd no done", 32'(stray), 32'h0);
      if_txn(32'h300, rd, lat, a0, a3);
      chk("refetch data", rd, 32'h4433_2211);
      chk("refetch lat",  32'(lat), 32'd6);

      // Simultaneous requests: data port first, then fetch
      @(negedge clk);
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b10; mem_addr_i = 32'h300;
      if_req_i  = 1'b1; if_addr_i = 32'h100;
      md_cyc = -1; id_cyc = -1; md_cnt = 0; id_cnt = 0; md_data = '0; id_data = '0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (mem_done_o) begin
            md_cnt++; md_cyc = c; md_data = mem_rdata_o; mem_req_i = 1'b0;
         end
         if (if_done_o) begin
            id_cnt++; id_cyc = c; id_data = if_data_o; if_req_i = 1'b0;
         end
      end
      chk("arb mdone cyc", 32'(md_cyc),  32'd6);
      chk("arb ifdone cyc", 32'(id_cyc), 32'd13);
      chk("arb mdone cnt", 32'(md_cnt),  32'd1);
      chk("arb ifdone cnt", 32'(id_cnt), 32'd1);
      chk("arb mdata",  md_data, 32'h4433_2211);
      chk("arb ifdata", id_data, 32'h0000_0013);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
